// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// Partial-product sum of one multiplier slice, placed at the current shift.
module mult_pp_step #(
    parameter int WIDTH   = 64,
    parameter int BPC     = 4,
    parameter int SHIFT_W = 6
) (
    input  logic [BPC-1:0]     slice,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [SHIFT_W-1:0] shift,
    output logic [2*WIDTH-1:0] pp
);

    // Sum of the selected shifted multiplicands; the result is below
    // 2^(WIDTH+BPC) before the shift, so it always fits 2*WIDTH bits.
    always_comb begin
        pp = '0;
        for (int i = 0; i < BPC; i++) begin
            if (slice[i]) begin
                pp = pp + ({{WIDTH{1'b0}}, mcand} << i);
            end
        end
        pp = pp << shift;
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: BITS_PER_CYCLE multiplier bits retired per
// clock, full 2*WIDTH product, signed/unsigned per transaction, valid/ready
// on both sides. Optional feature macro: MULT_OVF_FLAG_EN adds the ovf output,
// flagging products that do not fit the truncated WIDTH-bit result.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y
`ifdef MULT_OVF_FLAG_EN
    ,
    output logic               ovf
`endif
);

    localparam int ITERS   = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W   = cnt_width(ITERS);
    localparam int SHIFT_W = cnt_width(WIDTH);

    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must divide WIDTH");
    end

    mult_state_t        state_q;
    mult_state_t        state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] prod;
    logic               accept;

`ifdef MULT_OVF_FLAG_EN
    logic               sgn_q;

    // Product does not fit the WIDTH-bit truncated result.
    function automatic logic ovf_of(input logic [2*WIDTH-1:0] p, input logic s);
        if (s) return !((&p[2*WIDTH-1:WIDTH-1]) || (~|p[2*WIDTH-1:WIDTH-1]));
        else   return |p[2*WIDTH-1:WIDTH];
    endfunction
`endif

    mult_pp_step #(
        .WIDTH  (WIDTH),
        .BPC    (BITS_PER_CYCLE),
        .SHIFT_W(SHIFT_W)
    ) u_pp_step (
        .slice(mplier_q[BITS_PER_CYCLE-1:0]),
        .mcand(mcand_q),
        .shift(shift_q),
        .pp   (pp)
    );

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), exact as unsigned.
    always_comb begin
        a_mag  = (in_signed && a[WIDTH-1]) ? -a : a;
        b_mag  = (in_signed && b[WIDTH-1]) ? -b : b;
        accept = in_valid && in_ready;
        sum    = acc_q + pp;
        prod   = neg_q ? -sum : sum;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath: operand capture, per-cycle accumulation, result write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            y        <= '0;
`ifdef MULT_OVF_FLAG_EN
            sgn_q    <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_q    <= '0;
                        shift_q  <= '0;
                        cnt_q    <= CNT_W'(ITERS - 1);
`ifdef MULT_OVF_FLAG_EN
                        sgn_q    <= in_signed;
`endif
                    end
                end
                BUSY: begin
                    acc_q    <= sum;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    shift_q  <= shift_q + SHIFT_W'(BITS_PER_CYCLE);
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        y <= prod;
`ifdef MULT_OVF_FLAG_EN
                        ovf <= ovf_of(prod, sgn_q);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: a WIDTH=64 instance at BITS_PER_CYCLE=4
// plus instances at 1, 2, 8 and 64 driven by the same input bus.
module tb_seq_shift_add_multiplier;

    localparam int W   = 64;
    localparam int N   = 5;
    localparam int LIM = 300;

    function automatic int bpc_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 64;
        endcase
    endfunction

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_signed;
    logic           out_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [N-1:0]   in_ready_v;
    logic [N-1:0]   out_valid_v;
    logic [2*W-1:0] y_v [N];
`ifdef MULT_OVF_FLAG_EN
    logic [N-1:0]   ovf_v;
`endif

    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] got_y [N];
    int             got_lat;
    logic           got_to;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        seq_shift_add_multiplier #(
            .WIDTH         (W),
            .BITS_PER_CYCLE(bpc_of(g))
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .in_ready (in_ready_v[g]),
            .in_signed(in_signed),
            .a        (a),
            .b        (b),
            .out_valid(out_valid_v[g]),
            .out_ready(out_ready),
            .y        (y_v[g])
`ifdef MULT_OVF_FLAG_EN
            ,
            .ovf      (ovf_v[g])
`endif
        );
    end

    // Reference: mathematical product of the operands, sign- or zero-extended.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] z,
                                                input logic s);
        logic [2*W-1:0] xe;
        logic [2*W-1:0] ze;
        xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ze = s ? {{W{z[W-1]}}, z} : {{W{1'b0}}, z};
        return xe * ze;
    endfunction

    // Reference: product outside the representable WIDTH-bit range.
    function automatic logic ref_ovf(input logic [2*W-1:0] p, input logic s);
        logic signed [2*W-1:0] sp;
        sp = p;
        if (s) return (sp > $signed({{(W+1){1'b0}}, {(W-1){1'b1}}})) ||
                      (sp < $signed({{(W+1){1'b1}}, {(W-1){1'b0}}}));
        else   return p >= {{(W-1){1'b0}}, 1'b1, {W{1'b0}}};
    endfunction

    // Present one transaction to all instances, wait until all hold a result.
    task automatic start_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        int k;
        got_to = 1'b0;
        k = 0;
        while (in_ready_v != '1 && k < LIM) begin
            @(negedge clk);
            k++;
        end
        if (k >= LIM) got_to = 1'b1;
        a = ta;
        b = tb;
        in_signed = ts;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        got_lat = 0;
        while (!out_valid_v[0] && got_lat < LIM) begin
            @(posedge clk);
            got_lat++;
            @(negedge clk);
        end
        k = 0;
        while (out_valid_v != '1 && k < LIM) begin
            @(negedge clk);
            k++;
        end
        if (got_lat >= LIM || k >= LIM) got_to = 1'b1;
        for (int g = 0; g < N; g++) got_y[g] = y_v[g];
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready_v !== '1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp %b", in_ready_v, {N{1'b1}});
        end
        checks++;
        if (out_valid_v !== '0) begin
            errors++;
            $display("FAIL reset_out_valid got %b exp 0", out_valid_v);
        end
        for (int g = 0; g < N; g++) begin
            checks++;
            if (y_v[g] !== '0) begin
                errors++;
                $display("FAIL reset_y bpc=%0d got %h exp 0", bpc_of(g), y_v[g]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned_small;
        start_txn(64'd3, 64'd5, 1'b0);
        checks++;
        if (got_to !== 1'b0) begin
            errors++;
            $display("FAIL small_timeout got %b exp 0", got_to);
        end
        checks++;
        if (got_lat !== 16) begin
            errors++;
            $display("FAIL small_latency got %0d exp 16", got_lat);
        end
        for (int g = 0; g < N; g++) begin
            checks++;
            if (got_y[g] !== 128'd15) begin
                errors++;
                $display("FAIL small_y bpc=%0d got %h exp %h", bpc_of(g), got_y[g], 128'd15);
            end
        end
        release_out();
    endtask

    task automatic test_signed_small;
        start_txn(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1);
        checks++;
        if (got_to !== 1'b0 || got_lat !== 16) begin
            errors++;
            $display("FAIL signed_latency got %0d exp 16", got_lat);
        end
        for (int g = 0; g < N; g++) begin
            checks++;
            if (got_y[g] !== ~128'd14) begin
                errors++;
                $display("FAIL signed_y bpc=%0d got %h exp %h", bpc_of(g), got_y[g], ~128'd14);
            end
        end
        release_out();
    endtask

    task automatic test_unsigned_max;
        logic [2*W-1:0] exp_y;
        exp_y = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        start_txn('1, '1, 1'b0);
        for (int g = 0; g < N; g++) begin
            checks++;
            if (got_to !== 1'b0 || got_y[g] !== exp_y) begin
                errors++;
                $display("FAIL umax_y bpc=%0d got %h exp %h", bpc_of(g), got_y[g], exp_y);
            end
        end
`ifdef MULT_OVF_FLAG_EN
        checks++;
        if (ovf_v !== '1) begin
            errors++;
            $display("FAIL umax_ovf got %b exp %b", ovf_v, {N{1'b1}});
        end
`endif
        release_out();
    endtask

    task automatic test_most_negative;
        logic [2*W-1:0] exp_y;
        exp_y = {2'b01, 126'd0};
        start_txn({1'b1, 63'd0}, {1'b1, 63'd0}, 1'b1);
        for (int g = 0; g < N; g++) begin
            checks++;
            if (got_to !== 1'b0 || got_y[g] !== exp_y) begin
                errors++;
                $display("FAIL mostneg_y bpc=%0d got %h exp %h", bpc_of(g), got_y[g], exp_y);
            end
        end
`ifdef MULT_OVF_FLAG_EN
        checks++;
        if (ovf_v !== '1) begin
            errors++;
            $display("FAIL mostneg_ovf got %b exp %b", ovf_v, {N{1'b1}});
        end
`endif
        release_out();
    endtask

    task automatic test_hold_done;
        logic [W-1:0]   ta;
        logic [W-1:0]   tb;
        logic [2*W-1:0] exp_y;
        ta = {$urandom, $urandom};
        tb = {$urandom, $urandom};
        exp_y = ref_prod(ta, tb, 1'b0);
        start_txn(ta, tb, 1'b0);
        checks++;
        if (got_to !== 1'b0 || got_y[0] !== exp_y) begin
            errors++;
            $display("FAIL hold_y got %h exp %h", got_y[0], exp_y);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = ~ta;
            b = ~tb;
            @(negedge clk);
            checks++;
            if (y_v[0] !== exp_y || out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got y=%h ov=%b ir=%b exp y=%h ov=1 ir=0",
                         i, y_v[0], out_valid_v[0], in_ready_v[0], exp_y);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if (out_valid_v !== '0 || in_ready_v !== '1) begin
            errors++;
            $display("FAIL hold_release got ov=%b ir=%b exp ov=0 ir=all1", out_valid_v, in_ready_v);
        end
    endtask

    task automatic test_reset_mid;
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h0FED_CBA9_8765_4321;
        in_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL busy_flags got ir=%b ov=%b exp ir=0 ov=0", in_ready_v[0], out_valid_v[0]);
        end
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid_v !== '0 || in_ready_v !== '1 || y_v[0] !== '0) begin
            errors++;
            $display("FAIL midreset_state got ov=%b ir=%b y=%h exp ov=0 ir=all1 y=0",
                     out_valid_v, in_ready_v, y_v[0]);
        end
        reset = 1'b0;
        @(negedge clk);
        start_txn(64'd2, 64'd7, 1'b0);
        checks++;
        if (got_to !== 1'b0 || got_lat !== 16) begin
            errors++;
            $display("FAIL midreset_latency got %0d exp 16", got_lat);
        end
        for (int g = 0; g < N; g++) begin
            checks++;
            if (got_y[g] !== 128'd14) begin
                errors++;
                $display("FAIL midreset_y bpc=%0d got %h exp %h", bpc_of(g), got_y[g], 128'd14);
            end
        end
        release_out();
    endtask

    task automatic test_random;
        logic [W-1:0]   ta;
        logic [W-1:0]   tb;
        logic           ts;
        logic [2*W-1:0] exp_y;
        for (int t = 0; t < 24; t++) begin
            ta = {$urandom, $urandom};
            tb = {$urandom, $urandom};
            ts = 1'($urandom_range(0, 1));
            if (t % 6 == 1) ta = {1'b1, 63'd0};
            if (t % 6 == 2) tb = '1;
            if (t % 6 == 3) ta = {32'd0, ta[31:0]};
            exp_y = ref_prod(ta, tb, ts);
            start_txn(ta, tb, ts);
            checks++;
            if (got_to !== 1'b0 || got_lat !== 16) begin
                errors++;
                $display("FAIL rand_latency t=%0d got %0d exp 16", t, got_lat);
            end
            for (int g = 0; g < N; g++) begin
                checks++;
                if (got_y[g] !== exp_y) begin
                    errors++;
                    $display("FAIL rand_y t=%0d bpc=%0d s=%b a=%h b=%h got %h exp %h",
                             t, bpc_of(g), ts, ta, tb, got_y[g], exp_y);
                end
            end
`ifdef MULT_OVF_FLAG_EN
            checks++;
            if (ovf_v !== {N{ref_ovf(exp_y, ts)}}) begin
                errors++;
                $display("FAIL rand_ovf t=%0d got %b exp %b", t, ovf_v, {N{ref_ovf(exp_y, ts)}});
            end
`endif
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_small();
        test_signed_small();
        test_unsigned_max();
        test_most_negative();
        test_hold_done();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
